// File: rtl/leve2_ifetch_if.sv
// Signal bundle between the instruction fetch unit, its AXI read port and decode.
interface leve2_ifetch_if #(
   parameter int XLEN = 32
);
   logic            IPC_WE;
   logic [XLEN-1:0] INEXT_PC;

   logic            IF_VALID;
   logic            IF_READY;
   logic [XLEN-1:0] IF_PC;
   logic [31:0]     IF_INSTR;
   logic            IF_ERR;

   logic            RII_ARVALID;
   logic            RII_ARREADY;
   logic [XLEN-1:0] RII_ARADDR;

   logic            RII_RVALID;
   logic            RII_RREADY;
   logic [31:0]     RII_RDATA;
   logic [1:0]      RII_RRESP;

   modport master (
      input  IPC_WE, INEXT_PC,
      output IF_VALID, IF_PC, IF_INSTR, IF_ERR,
      input  IF_READY,
      output RII_ARVALID, RII_ARADDR,
      input  RII_ARREADY,
      input  RII_RVALID, RII_RDATA, RII_RRESP,
      output RII_RREADY
   );

   modport slave (
      output IPC_WE, INEXT_PC,
      input  IF_VALID, IF_PC, IF_INSTR, IF_ERR,
      output IF_READY,
      input  RII_ARVALID, RII_ARADDR,
      output RII_ARREADY,
      output RII_RVALID, RII_RDATA, RII_RRESP,
      input  RII_RREADY
   );
endinterface

// File: rtl/leve2_ifetch.sv
// Sequential instruction prefetcher: issues AXI reads ahead of decode into a small
// queue, with redirect support that discards responses still in flight.
module leve2_ifetch #(
   parameter int              XLEN         = 32,
   parameter int              DEPTH        = 4,
   parameter int              MAX_OUT      = 2,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
   input logic            CLK,
   input logic            RSTn,
   leve2_ifetch_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int OW = $clog2(MAX_OUT) + 1;
   localparam int SW = 6;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
      logic            err;
   } entry_t;

   logic            run_reg;
   logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
   logic [XLEN-1:0] resp_pc_reg, resp_pc_next;
   logic [OW-1:0]   outstanding_reg, outstanding_next;
   logic [OW-1:0]   drop_cnt_reg, drop_cnt_next;
   logic            head_valid_reg, head_valid_next;
   entry_t          head_reg, head_next;
   entry_t          tail_mem [DEPTH];
   logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0]   tail_cnt_reg, tail_cnt_next;

   logic            ar_valid, ar_hs, r_hs, redirect;
   logic            push, pop, head_load, pull_tail, push_tail;
   logic [SW-1:0]   occupancy;
   logic [XLEN-1:0] target_pc;
   entry_t          r_entry;

   assign target_pc = {bus.INEXT_PC[XLEN-1:2], 2'b00};

   // Reads still in flight (including ones to be discarded) reserve queue space.
   assign occupancy = SW'(outstanding_reg) + SW'(tail_cnt_reg) + SW'(head_valid_reg);
   assign ar_valid  = run_reg && (outstanding_reg < OW'(MAX_OUT)) && (occupancy < SW'(DEPTH));
   assign ar_hs     = ar_valid && bus.RII_ARREADY;
   assign r_hs      = run_reg && bus.RII_RVALID;
   assign redirect  = bus.IPC_WE;

   assign push      = r_hs && !redirect && (drop_cnt_reg == '0);
   assign pop       = head_valid_reg && bus.IF_READY;
   assign head_load = !head_valid_reg || pop;
   assign pull_tail = head_load && (tail_cnt_reg != '0);
   assign push_tail = push && !(head_load && (tail_cnt_reg == '0));

   assign r_entry = '{pc: resp_pc_reg, instr: bus.RII_RDATA, err: (bus.RII_RRESP != 2'b00)};

   always_comb begin
      fetch_pc_next    = fetch_pc_reg;
      resp_pc_next     = resp_pc_reg;
      outstanding_next = outstanding_reg + OW'(ar_hs) - OW'(r_hs);
      drop_cnt_next    = drop_cnt_reg;
      head_valid_next  = head_valid_reg;
      head_next        = head_reg;
      wr_ptr_next      = wr_ptr_reg;
      rd_ptr_next      = rd_ptr_reg;
      tail_cnt_next    = tail_cnt_reg;

      if (redirect) begin
         // Everything still outstanding after this cycle belongs to the old stream.
         fetch_pc_next   = target_pc;
         resp_pc_next    = target_pc;
         drop_cnt_next   = outstanding_next;
         head_valid_next = 1'b0;
         wr_ptr_next     = '0;
         rd_ptr_next     = '0;
         tail_cnt_next   = '0;
      end else begin
         if (ar_hs) begin
            fetch_pc_next = fetch_pc_reg + XLEN'(4);
         end
         if (push) begin
            resp_pc_next = resp_pc_reg + XLEN'(4);
         end
         if (r_hs && (drop_cnt_reg != '0)) begin
            drop_cnt_next = drop_cnt_reg - OW'(1);
         end

         if (pull_tail) begin
            head_next       = tail_mem[rd_ptr_reg];
            head_valid_next = 1'b1;
            rd_ptr_next     = rd_ptr_reg + PW'(1);
         end else if (head_load) begin
            head_valid_next = push;
            if (push) begin
               head_next = r_entry;
            end
         end

         if (push_tail) begin
            wr_ptr_next = wr_ptr_reg + PW'(1);
         end
         tail_cnt_next = tail_cnt_reg + CW'(push_tail) - CW'(pull_tail);
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         run_reg         <= 1'b0;
         fetch_pc_reg    <= RESET_VECTOR;
         resp_pc_reg     <= RESET_VECTOR;
         outstanding_reg <= '0;
         drop_cnt_reg    <= '0;
         head_valid_reg  <= 1'b0;
         head_reg        <= '0;
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         tail_cnt_reg    <= '0;
      end else begin
         run_reg         <= 1'b1;
         fetch_pc_reg    <= fetch_pc_next;
         resp_pc_reg     <= resp_pc_next;
         outstanding_reg <= outstanding_next;
         drop_cnt_reg    <= drop_cnt_next;
         head_valid_reg  <= head_valid_next;
         head_reg        <= head_next;
         wr_ptr_reg      <= wr_ptr_next;
         rd_ptr_reg      <= rd_ptr_next;
         tail_cnt_reg    <= tail_cnt_next;
      end
   end

   // Queue body behind the head register; contents need no reset.
   always_ff @(posedge CLK) begin
      if (push_tail) begin
         tail_mem[wr_ptr_reg] <= r_entry;
      end
   end

   assign bus.RII_ARVALID = ar_valid;
   assign bus.RII_ARADDR  = fetch_pc_reg;
   assign bus.RII_RREADY  = run_reg;
   assign bus.IF_VALID    = head_valid_reg;
   assign bus.IF_PC       = head_reg.pc;
   assign bus.IF_INSTR    = head_reg.instr;
   assign bus.IF_ERR      = head_reg.err;
endmodule

// File: tb/tb_leve2_ifetch.sv
// Scoreboard bench for leve2_ifetch: AXI read slave model, directed fetch streams,
// and a monitor comparing every consumed instruction against the expected queue.
module tb_leve2_ifetch;
   localparam int XLEN = 32;

   logic CLK = 1'b0;
   logic RSTn = 1'b0;
   always #5 CLK = ~CLK;

   leve2_ifetch_if #(.XLEN(XLEN)) bus ();

   leve2_ifetch #(
      .XLEN(XLEN), .DEPTH(4), .MAX_OUT(2), .RESET_VECTOR(32'h0)
   ) dut (
      .CLK(CLK), .RSTn(RSTn), .bus(bus)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        err;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   exp_t        exp_q [$];
   pend_t       pend_q [$];
   int          vectors = 0;
   int          miscompares = 0;
   int          consumed = 0;
   int          cyc = 0;
   int          lat = 1;
   int          ar_mode = 0;
   int          beats = 0;
   int          max_out = 0;
   bit          ar_fire, r_fire;
   logic [31:0] ar_addr_s;
   logic [31:0] err_addr = 32'h8;

   function automatic logic [31:0] mem_word(logic [31:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   // Slave handshakes are sampled mid-cycle and take effect at the next edge.
   initial forever begin
      @(negedge CLK);
      ar_fire   = bus.RII_ARVALID && bus.RII_ARREADY;
      ar_addr_s = bus.RII_ARADDR;
      r_fire    = bus.RII_RVALID && bus.RII_RREADY;
   end

   initial begin
      bus.RII_ARREADY = 1'b1;
      bus.RII_RVALID  = 1'b0;
      bus.RII_RDATA   = '0;
      bus.RII_RRESP   = '0;
      forever begin
         @(posedge CLK);
         #1;
         cyc++;
         if (!RSTn) begin
            pend_q.delete();
            beats   = 0;
            max_out = 0;
         end else begin
            if (r_fire) begin
               void'(pend_q.pop_front());
               beats++;
            end
            if (ar_fire) pend_q.push_back('{addr: ar_addr_s, due: cyc + lat - 1});
            if (pend_q.size() > max_out) max_out = pend_q.size();
         end
         bus.RII_RVALID = 1'b0;
         bus.RII_RDATA  = '0;
         bus.RII_RRESP  = 2'b00;
         if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            bus.RII_RVALID = 1'b1;
            bus.RII_RDATA  = mem_word(pend_q[0].addr);
            bus.RII_RRESP  = (pend_q[0].addr == err_addr) ? 2'b10 : 2'b00;
         end
         bus.RII_ARREADY = (ar_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      end
   end

   // Monitor: one line per consumed instruction.
   initial forever begin
      @(negedge CLK);
      if (RSTn && bus.IF_VALID && bus.IF_READY) begin
         vectors++;
         consumed++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL fetch %0d unexpected: got pc=0x%08h instr=0x%08h err=%0b, required nothing",
                     consumed, bus.IF_PC, bus.IF_INSTR, bus.IF_ERR);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (bus.IF_PC !== e.pc || bus.IF_INSTR !== e.instr || bus.IF_ERR !== e.err) begin
               miscompares++;
               $display("FAIL fetch %0d: got pc=0x%08h instr=0x%08h err=%0b, required pc=0x%08h instr=0x%08h err=%0b",
                        consumed, bus.IF_PC, bus.IF_INSTR, bus.IF_ERR, e.pc, e.instr, e.err);
            end else begin
               $display("fetch %0d: pc=0x%08h instr=0x%08h err=%0b ok",
                        consumed, bus.IF_PC, bus.IF_INSTR, bus.IF_ERR);
            end
         end
      end
   end

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end else begin
         $display("check %s: 0x%0h ok", name, act);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic load_stream(logic [31:0] start, int n);
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         logic [31:0] a;
         a = start + 32'(4 * i);
         exp_q.push_back('{pc: a, instr: mem_word(a), err: (a == err_addr)});
      end
   endtask

   task automatic consume(int n);
      int target;
      int t;
      target = consumed + n;
      t = 0;
      bus.IF_READY = 1'b1;
      while (consumed < target && t < 400) begin
         tick();
         t++;
      end
      bus.IF_READY = 1'b0;
      check("consumed count", 64'(consumed), 64'(target));
   endtask

   task automatic redirect(logic [31:0] tgt);
      bus.IPC_WE   = 1'b1;
      bus.INEXT_PC = tgt;
      tick();
      bus.IPC_WE = 1'b0;
      check("IF_VALID after redirect", 64'(bus.IF_VALID), 64'h0);
   endtask

   task automatic check_reset_outputs();
      check("reset IF_VALID", 64'(bus.IF_VALID), 64'h0);
      check("reset IF_PC", 64'(bus.IF_PC), 64'h0);
      check("reset IF_INSTR", 64'(bus.IF_INSTR), 64'h0);
      check("reset IF_ERR", 64'(bus.IF_ERR), 64'h0);
      check("reset ARVALID", 64'(bus.RII_ARVALID), 64'h0);
      check("reset RREADY", 64'(bus.RII_RREADY), 64'h0);
   endtask

   task automatic release_reset();
      RSTn = 1'b1;
      check("ARVALID while reset releases", 64'(bus.RII_ARVALID), 64'h0);
      tick();
      check("first ARVALID", 64'(bus.RII_ARVALID), 64'h1);
      check("first ARADDR", 64'(bus.RII_ARADDR), 64'h0);
   endtask

   initial begin
      int t;
      bus.IF_READY = 1'b0;
      bus.IPC_WE   = 1'b0;
      bus.INEXT_PC = '0;

      // Reset, streaming with an error beat at 0x8, then backpressure.
      repeat (3) tick();
      check_reset_outputs();
      load_stream(32'h0, 40);
      release_reset();
      consume(12);
      repeat (20) tick();
      check("held ARVALID", 64'(bus.RII_ARVALID), 64'h0);
      check("held IF_VALID", 64'(bus.IF_VALID), 64'h1);
      check("held IF_PC", 64'(bus.IF_PC), 64'h30);
      check("beats accepted while held", 64'(beats), 64'd16);
      check("reads pending while held", 64'(pend_q.size()), 64'h0);
      consume(8);
      check("max outstanding within limit", 64'(max_out <= 2), 64'h1);

      // Redirect with two reads in flight.
      lat = 3;
      bus.IF_READY = 1'b1;
      t = 0;
      while (pend_q.size() != 2 && t < 100) begin
         tick();
         t++;
      end
      check("two reads in flight", 64'(pend_q.size()), 64'd2);
      redirect(32'h100);
      load_stream(32'h100, 20);
      consume(6);

      // Redirect coinciding with an AR handshake and an R beat.
      lat = 1;
      bus.IF_READY = 1'b1;
      t = 0;
      while (!(bus.RII_ARVALID && bus.RII_ARREADY && bus.RII_RVALID) && t < 100) begin
         tick();
         t++;
      end
      check("AR and R together", 64'(bus.RII_ARVALID && bus.RII_ARREADY && bus.RII_RVALID), 64'h1);
      redirect(32'h200);
      load_stream(32'h200, 20);
      consume(6);

      // Back-to-back redirects with slower, gapped AR acceptance.
      lat = 2;
      ar_mode = 1;
      bus.IF_READY = 1'b1;
      repeat (5) tick();
      bus.IPC_WE   = 1'b1;
      bus.INEXT_PC = 32'h300;
      tick();
      check("IF_VALID after first redirect", 64'(bus.IF_VALID), 64'h0);
      bus.INEXT_PC = 32'h400;
      tick();
      bus.IPC_WE = 1'b0;
      check("IF_VALID after second redirect", 64'(bus.IF_VALID), 64'h0);
      load_stream(32'h400, 20);
      consume(6);

      // Unaligned target near the top of the address space wraps to zero.
      redirect(32'hFFFF_FFFF);
      check("ARADDR after wrap redirect", 64'(bus.RII_ARADDR), 64'hFFFF_FFFC);
      load_stream(32'hFFFF_FFFC, 24);
      consume(5);

      // Reset in the middle of streaming.
      lat = 1;
      ar_mode = 0;
      bus.IF_READY = 1'b1;
      repeat (6) tick();
      RSTn = 1'b0;
      tick();
      check_reset_outputs();
      tick();
      load_stream(32'h0, 16);
      release_reset();
      consume(4);
      check("max outstanding after reset", 64'(max_out <= 2), 64'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
